// File: rtl/inst_fetch_unit.sv
// Instruction fetch front end: walks a fetch PC across the combinational ROM and
// buffers returned words in a small prefetch queue that feeds decode.
module inst_fetch_unit #(
    parameter logic [63:0] RESET_PC       = 64'h0,
    parameter int          QUEUE_DEPTH    = 4,
    parameter int          IMEM_ADDR_BITS = 14
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        fetch_en,
    output logic [63:0] im_addr,
    input  logic [31:0] im_dout,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_inst,
    output logic [63:0] out_pc,
    output logic        out_fault
);
    localparam int                PTR_W      = $clog2(QUEUE_DEPTH);
    localparam logic [PTR_W:0]    FULL_COUNT = (PTR_W + 1)'(QUEUE_DEPTH);
    localparam logic [PTR_W:0]    ONE_COUNT  = (PTR_W + 1)'(1);
    localparam logic [PTR_W-1:0]  ONE_PTR    = PTR_W'(1);

    logic [63:0]      fetch_pc_reg;
    logic             halted_reg;
    logic [PTR_W-1:0] head_reg;
    logic [PTR_W-1:0] tail_reg;
    logic [PTR_W:0]   count_reg;

    logic [31:0] inst_q  [QUEUE_DEPTH];
    logic [63:0] pc_q    [QUEUE_DEPTH];
    logic        fault_q [QUEUE_DEPTH];

    logic fault_now;
    logic pop;
    logic enq;

    assign im_addr   = fetch_pc_reg;
    assign fault_now = (fetch_pc_reg[63:IMEM_ADDR_BITS] != '0) || (fetch_pc_reg[1:0] != 2'b00);
    assign out_valid = (count_reg != '0);
    assign pop       = out_valid && out_ready && !redirect_valid;
    // A pop on the same edge frees the slot, so a full queue can still accept.
    assign enq       = fetch_en && !halted_reg && !redirect_valid &&
                       ((count_reg != FULL_COUNT) || pop);

    assign out_inst  = inst_q[head_reg];
    assign out_pc    = pc_q[head_reg];
    assign out_fault = fault_q[head_reg];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc_reg <= RESET_PC;
            halted_reg   <= 1'b0;
            head_reg     <= '0;
            tail_reg     <= '0;
            count_reg    <= '0;
        end else if (redirect_valid) begin
            fetch_pc_reg <= redirect_pc;
            halted_reg   <= 1'b0;
            head_reg     <= '0;
            tail_reg     <= '0;
            count_reg    <= '0;
        end else begin
            if (pop) begin
                head_reg <= head_reg + ONE_PTR;
            end
            if (enq) begin
                tail_reg <= tail_reg + ONE_PTR;
                // A faulting fetch parks the PC until execute redirects us.
                if (fault_now) begin
                    halted_reg <= 1'b1;
                end else begin
                    fetch_pc_reg <= fetch_pc_reg + 64'd4;
                end
            end
            case ({enq, pop})
                2'b10:   count_reg <= count_reg + ONE_COUNT;
                2'b01:   count_reg <= count_reg - ONE_COUNT;
                default: count_reg <= count_reg;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < QUEUE_DEPTH; i++) begin
                inst_q[i]  <= '0;
                pc_q[i]    <= '0;
                fault_q[i] <= 1'b0;
            end
        end else if (enq) begin
            inst_q[tail_reg]  <= fault_now ? 32'h0 : im_dout;
            pc_q[tail_reg]    <= fetch_pc_reg;
            fault_q[tail_reg] <= fault_now;
        end
    end
endmodule

// File: tb/tb_inst_fetch_unit.sv
// Bench for inst_fetch_unit: a queue-based fetch model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_inst_fetch_unit;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        fetch_en;
    logic [63:0] im_addr;
    logic [31:0] im_dout;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_inst;
    logic [63:0] out_pc;
    logic        out_fault;

    logic [31:0] rom [0:4095];

    typedef struct {
        logic [31:0] inst;
        logic [63:0] pc;
        logic        fault;
    } ent_t;

    ent_t        mq[$];
    logic [63:0] m_pc;
    logic        m_halted;

    int tests = 0;
    int fails = 0;

    inst_fetch_unit #(
        .RESET_PC      (64'h0),
        .QUEUE_DEPTH   (4),
        .IMEM_ADDR_BITS(14)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .fetch_en      (fetch_en),
        .im_addr       (im_addr),
        .im_dout       (im_dout),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_inst      (out_inst),
        .out_pc        (out_pc),
        .out_fault     (out_fault)
    );

    always #5 clk = ~clk;

    assign im_dout = rom[im_addr[13:2]];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_pc     = 64'h0;
        m_halted = 1'b0;
    endtask

    // Reference behaviour for one clock edge, from the pre-edge inputs.
    task automatic model_step();
        bit   do_pop;
        bit   do_enq;
        ent_t e;
        if (!rst_n) return;
        do_pop = (mq.size() != 0) && out_ready && !redirect_valid;
        if (redirect_valid) begin
            mq.delete();
            m_pc     = redirect_pc;
            m_halted = 1'b0;
            return;
        end
        do_enq = fetch_en && !m_halted && (mq.size() < 4 || do_pop);
        if (do_pop) void'(mq.pop_front());
        if (do_enq) begin
            e.pc    = m_pc;
            e.fault = ((m_pc >> 14) != 0) || (m_pc % 4 != 0);
            e.inst  = e.fault ? 32'h0 : rom[(m_pc % 16384) / 4];
            mq.push_back(e);
            if (e.fault) m_halted = 1'b1;
            else         m_pc = m_pc + 64'd4;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic do_reset();
        #2;
        rst_n = 1'b0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Per-cycle comparison against the model, on the falling edge.
    initial begin
        forever begin
            @(negedge clk);
            chk("out_valid", 64'(out_valid), 64'(mq.size() != 0));
            chk("im_addr", im_addr, m_pc);
            if (mq.size() != 0) begin
                chk("out_inst", 64'(out_inst), 64'(mq[0].inst));
                chk("out_pc", out_pc, mq[0].pc);
                chk("out_fault", 64'(out_fault), 64'(mq[0].fault));
            end
        end
    end

    initial begin
        for (int i = 0; i < 4096; i++) rom[i] = $urandom;
        rom[0] = 32'h00000093;
        rom[1] = 32'h00100113;
        rom[2] = 32'h00208193;
        rom[3] = 32'h00000013;

        rst_n          = 1'b0;
        fetch_en       = 1'b1;
        out_ready      = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 64'h0;
        model_reset();

        // Reset state
        #2;
        chk("rst_valid", 64'(out_valid), 64'h0);
        chk("rst_inst", 64'(out_inst), 64'h0);
        chk("rst_pc", out_pc, 64'h0);
        chk("rst_fault", 64'(out_fault), 64'h0);
        chk("rst_addr", im_addr, 64'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Streaming from reset with decode always ready
        tick();
        chk("s1_valid", 64'(out_valid), 64'h1);
        chk("s1_pc", out_pc, 64'h0);
        chk("s1_inst", 64'(out_inst), 64'h00000093);
        tick();
        chk("s2_pc", out_pc, 64'h4);
        chk("s2_inst", 64'(out_inst), 64'h00100113);
        tick();
        chk("s3_pc", out_pc, 64'h8);
        chk("s3_inst", 64'(out_inst), 64'h00208193);
        tick();
        chk("s4_pc", out_pc, 64'hC);
        chk("s4_inst", 64'(out_inst), 64'h00000013);

        // Backpressure: queue fills and fetch stalls, then drains with no bubble
        out_ready = 1'b0;
        do_reset();
        for (int i = 0; i < 10; i++) tick();
        chk("bp_addr", im_addr, 64'h10);
        chk("bp_pc", out_pc, 64'h0);
        chk("bp_valid", 64'(out_valid), 64'h1);
        out_ready = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            tick();
            chk("drain_valid", 64'(out_valid), 64'h1);
            chk("drain_pc", out_pc, 64'(4 * k));
        end

        // Redirect with three queued entries and ready asserted in the same cycle
        out_ready = 1'b0;
        do_reset();
        for (int i = 0; i < 3; i++) tick();
        out_ready      = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 64'h100;
        tick();
        redirect_valid = 1'b0;
        chk("rd_bubble", 64'(out_valid), 64'h0);
        tick();
        chk("rd_valid", 64'(out_valid), 64'h1);
        chk("rd_pc", out_pc, 64'h100);
        chk("rd_inst", 64'(out_inst), 64'(rom[64]));

        // Run off the top of the ROM
        out_ready      = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 64'h3FFC;
        tick();
        redirect_valid = 1'b0;
        tick();
        chk("top_pc", out_pc, 64'h3FFC);
        chk("top_fault", 64'(out_fault), 64'h0);
        tick();
        chk("top_addr", im_addr, 64'h4000);
        out_ready = 1'b1;
        tick();
        chk("oor_pc", out_pc, 64'h4000);
        chk("oor_fault", 64'(out_fault), 64'h1);
        chk("oor_inst", 64'(out_inst), 64'h0);
        tick();
        chk("oor_empty", 64'(out_valid), 64'h0);
        for (int i = 0; i < 3; i++) tick();
        chk("oor_hold", im_addr, 64'h4000);

        // Misaligned redirect faults once, then a clean redirect resumes
        redirect_valid = 1'b1;
        redirect_pc    = 64'h102;
        tick();
        redirect_valid = 1'b0;
        tick();
        chk("mis_pc", out_pc, 64'h102);
        chk("mis_fault", 64'(out_fault), 64'h1);
        tick();
        tick();
        chk("mis_empty", 64'(out_valid), 64'h0);
        chk("mis_hold", im_addr, 64'h102);
        redirect_valid = 1'b1;
        redirect_pc    = 64'h0;
        tick();
        redirect_valid = 1'b0;
        tick();
        chk("res_pc", out_pc, 64'h0);
        chk("res_inst", 64'(out_inst), 64'h00000093);

        // Asynchronous reset with a full queue
        out_ready = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("arst_valid", 64'(out_valid), 64'h0);
        chk("arst_addr", im_addr, 64'h0);
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        tick();
        chk("arst_resume", out_pc, 64'h0);

        // Randomized traffic
        for (int n = 0; n < 1500; n++) begin
            fetch_en       = ($urandom_range(0, 9) != 0);
            out_ready      = ($urandom_range(0, 1) != 0);
            redirect_valid = ($urandom_range(0, 19) == 0);
            case ($urandom_range(0, 9))
                0:       redirect_pc = {$urandom, $urandom};
                1:       redirect_pc = 64'h3FF0 + 64'(4 * $urandom_range(0, 3));
                2:       redirect_pc = 64'($urandom_range(0, 16383)) | 64'h1;
                default: redirect_pc = 64'($urandom_range(0, 4095)) * 4;
            endcase
            if ($urandom_range(0, 299) == 0) begin
                redirect_valid = 1'b0;
                do_reset();
            end else begin
                tick();
            end
        end
        redirect_valid = 1'b0;
        tick();
        #1;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/inst_fetch_unit.md
Name: inst_fetch_unit

Overview:
Instruction-fetch initiator that drives the combinational instruction ROM. It issues word addresses from a fetch PC and captures returned instructions into a small prefetch queue. The queue presents instructions to decode over a valid/ready handshake. It sits between the ROM and the decode stage, and accepts branch/jump redirects from execute.

Parameters:
RESET_PC, 64'h0, fetch PC loaded on reset
QUEUE_DEPTH, 4, prefetch queue entries (power of two, >=2)
IMEM_ADDR_BITS, 14, byte-address width covered by the ROM (4096 words)

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
fetch_en  input  1  1 = fetching allowed; 0 = hold fetch PC, queue drains normally
im_addr  output  64  byte address to ROM; combinationally equals fetch_pc
im_dout  input  32  instruction from ROM; combinational response to im_addr, same cycle
redirect_valid  input  1  flush and restart fetch this cycle
redirect_pc  input  64  new fetch PC when redirect_valid=1
out_valid  output  1  queue head valid
out_ready  input  1  decode accepts head when out_valid && out_ready
out_inst  output  32  head instruction
out_pc  output  64  head instruction address
out_fault  output  1  head is an access fault (out-of-range or misaligned)

Behaviour:
- Reset (async, rst_n=0):
  - fetch_pc=RESET_PC; queue empty; count=0; halted=0.
  - out_valid=0, out_inst=0, out_pc=0, out_fault=0.
  - Takes effect immediately, including mid-operation; all in-flight entries are discarded.
- im_addr is purely combinational from fetch_pc.
- Fault condition:
  - fault = fetch_pc[63:IMEM_ADDR_BITS]!=0 OR fetch_pc[1:0]!=0.
- Enqueue:
  - Condition: fetch_en && !halted && !redirect_valid && (count<QUEUE_DEPTH || pop).
  - Action: on the clock edge, write {inst, fetch_pc, fault} at tail.
  - inst = im_dout when fault=0, and 32'h0 when fault=1.
  - After a non-fault enqueue: fetch_pc <= fetch_pc+4, with 64-bit wrap modulo 2^64.
  - After a fault enqueue: halted<=1 and fetch_pc holds. No further fetch until redirect.
- Pop:
  - pop = out_valid && out_ready && !redirect_valid.
  - Head advances on the edge.
  - Pop and enqueue on the same edge is legal when full; count is unchanged.
- Outputs are driven from the head entry (registered storage). out_valid = (count!=0).
- Latency:
  - The instruction at fetch_pc is visible at the outputs 1 cycle after the enqueue edge.
  - After reset release, the first enqueue happens on the first edge and out_valid=1 after it.
- Full (count=QUEUE_DEPTH) with no pop: no enqueue; fetch_pc and im_addr stay stable.
- Empty: out_valid=0; out_inst/out_pc/out_fault hold their last values (don't-care).
- Redirect:
  - redirect_valid=1 wins over pop and enqueue in the same cycle.
  - On that edge: queue flushed (count=0), fetch_pc<=redirect_pc, halted<=0.
  - out_valid=0 in the following cycle.
  - The first redirected instruction is enqueued on the next edge and appears 2 edges after the redirect edge.
  - A misaligned or out-of-range redirect_pc is accepted and produces a single fault entry.
- fetch_en=0: no enqueue and fetch_pc holds. Pops and redirects still operate.
- Queue pointers are log2(QUEUE_DEPTH) bits and wrap naturally. count is log2(QUEUE_DEPTH)+1 bits.

Test Plan:
- Reset with ROM words 0..3 = 32'h00000093, 32'h00100113, 32'h00208193, 32'h00000013; hold out_ready=1 -> out_pc sequence 0,4,8,12 on consecutive cycles; out_valid first high after edge 1; out_inst matches ROM words in order.
- Hold out_ready=0 for 10 cycles -> count saturates at 4; im_addr holds 64'h10; out_pc=0 held. Release out_ready -> out_pc 0,4,8,12,16 back-to-back with no bubble.
- Redirect to 64'h100 while the queue holds 3 entries and out_ready=1 in the same cycle -> no pop counted; out_valid=0 for 1 cycle; next out_pc=64'h100 with inst = word 64.
- Redirect to 64'h3FFC -> entry 64'h3FFC valid with fault=0; then entry 64'h4000 with fault=1 and inst=0; out_valid drops after it drains; im_addr stays 64'h4000 until a redirect.
- Redirect to 64'h102 -> a single entry with out_fault=1 and out_pc=64'h102; fetch halts. A following redirect to 64'h0 resumes normal fetch from 0.
- Assert rst_n=0 asynchronously mid-stream with a full queue -> out_valid=0 and im_addr=RESET_PC immediately, without waiting for a clock edge; normal fetch resumes after release.
